// File: rtl/hbm_channel_port.sv
// HBM pseudo-channel port: credit-limited read-address issue with base offset, and a
// response buffer whose head word is split into independently handshaked core lanes.
module hbm_channel_port #(
  parameter int unsigned     HBM_AWIDTH     = 33,
  parameter int unsigned     HBM_DWIDTH     = 256,
  parameter int unsigned     GROUP_CORE_NUM = 8,
  parameter longint unsigned BASE_OFFSET    = 0,
  parameter int unsigned     REQ_DEPTH      = 16,
  parameter int unsigned     REQ_SLACK      = 4,
  parameter int unsigned     RSP_DEPTH      = 32,
  localparam int unsigned    LANE_W         = HBM_DWIDTH / GROUP_CORE_NUM,
  localparam int unsigned    OUT_W          = $clog2(RSP_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [HBM_AWIDTH-1:0]            front_rd_hbm_edge_addr,
  input  logic                             front_rd_hbm_edge_valid,
  output logic                             stage_full,
  input  logic                             hbm_controller_full,
  output logic [HBM_AWIDTH-1:0]            rd_hbm_edge_addr,
  output logic                             rd_hbm_edge_valid,
  input  logic [HBM_DWIDTH-1:0]            hbm_controller_edge,
  input  logic                             hbm_controller_valid,
  output logic [GROUP_CORE_NUM*LANE_W-1:0] active_v_edge,
  output logic [GROUP_CORE_NUM-1:0]        active_v_edge_valid,
  input  logic [GROUP_CORE_NUM-1:0]        active_v_edge_ready,
  output logic [OUT_W-1:0]                 outstanding,
  output logic                             err_drop
);

  localparam int unsigned RQ_AW = $clog2(REQ_DEPTH);
  localparam int unsigned RQ_CW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned RS_AW = $clog2(RSP_DEPTH);

  // Request FIFO
  logic [HBM_AWIDTH-1:0] req_mem [REQ_DEPTH];
  logic [RQ_AW-1:0]      req_wp, req_rp;
  logic [RQ_CW-1:0]      req_cnt;
  logic                  req_full, req_wr, req_drop, issue;

  // Response FIFO and lane tracking
  logic [HBM_DWIDTH-1:0]     rsp_mem [RSP_DEPTH];
  logic [RS_AW-1:0]          rsp_wp, rsp_rp;
  logic [OUT_W-1:0]          rsp_cnt;
  logic                      rsp_full, rsp_empty, rsp_wr, rsp_drop, pop;
  logic [GROUP_CORE_NUM-1:0] lane_done, lane_fire, lane_all;
  logic                      out_dec;

  assign req_full   = (req_cnt == RQ_CW'(REQ_DEPTH));
  assign req_wr     = front_rd_hbm_edge_valid && !req_full;
  assign req_drop   = front_rd_hbm_edge_valid && req_full;
  assign stage_full = (req_cnt >= RQ_CW'(REQ_DEPTH - REQ_SLACK));

  // Credits are held as the outstanding count; a credit exists while outstanding < RSP_DEPTH.
  assign issue = (req_cnt != '0) && (outstanding < OUT_W'(RSP_DEPTH)) && !hbm_controller_full;

  assign rsp_full  = (rsp_cnt == OUT_W'(RSP_DEPTH));
  assign rsp_empty = (rsp_cnt == '0);
  assign rsp_wr    = hbm_controller_valid && !rsp_full;
  assign rsp_drop  = hbm_controller_valid && rsp_full;

  assign active_v_edge_valid = {GROUP_CORE_NUM{!rsp_empty}} & ~lane_done;
  assign active_v_edge       = rsp_empty ? '0 : rsp_mem[rsp_rp];
  assign lane_fire           = active_v_edge_valid & active_v_edge_ready;
  assign lane_all            = lane_done | lane_fire;
  assign pop                 = !rsp_empty && (&lane_all);
  assign out_dec             = pop && (outstanding != '0);

  // Storage arrays carry no reset; occupancy is tracked by the counters below.
  always_ff @(posedge clk) begin
    if (req_wr) req_mem[req_wp] <= front_rd_hbm_edge_addr + HBM_AWIDTH'(BASE_OFFSET);
    if (rsp_wr) rsp_mem[rsp_wp] <= hbm_controller_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wp            <= '0;
      req_rp            <= '0;
      req_cnt           <= '0;
      rd_hbm_edge_addr  <= '0;
      rd_hbm_edge_valid <= 1'b0;
    end else begin
      if (req_wr) req_wp <= req_wp + RQ_AW'(1);
      if (issue) begin
        req_rp           <= req_rp + RQ_AW'(1);
        rd_hbm_edge_addr <= req_mem[req_rp];
      end
      req_cnt           <= req_cnt + RQ_CW'(req_wr) - RQ_CW'(issue);
      rd_hbm_edge_valid <= issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wp      <= '0;
      rsp_rp      <= '0;
      rsp_cnt     <= '0;
      lane_done   <= '0;
      outstanding <= '0;
      err_drop    <= 1'b0;
    end else begin
      if (rsp_wr) rsp_wp <= rsp_wp + RS_AW'(1);
      if (pop)    rsp_rp <= rsp_rp + RS_AW'(1);
      rsp_cnt     <= rsp_cnt + OUT_W'(rsp_wr) - OUT_W'(pop);
      lane_done   <= pop ? '0 : lane_all;
      outstanding <= outstanding + OUT_W'(issue) - OUT_W'(out_dec);
      err_drop    <= err_drop | req_drop | rsp_drop;
    end
  end

endmodule

// File: tb/tb_hbm_channel_port.sv
// Scoreboard bench for hbm_channel_port: directed stimulus pushes expected addresses and
// words; a negedge monitor checks issued addresses and per-lane data as they appear.
module tb_hbm_channel_port;

  localparam int unsigned AW = 33;
  localparam int unsigned DW = 256;
  localparam int unsigned NL = 8;
  localparam int unsigned LW = 32;
  localparam int unsigned OW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] front_addr;
  logic          front_valid;
  logic          stage_full;
  logic          ctrl_full;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] ctrl_edge;
  logic          ctrl_valid;
  logic [DW-1:0] lane_data;
  logic [NL-1:0] lane_valid;
  logic [NL-1:0] lane_ready;
  logic [OW-1:0] outstanding;
  logic          err_drop;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_word [$];
  logic [NL-1:0] seen_mask;

  always #5 clk = ~clk;

  hbm_channel_port #(.BASE_OFFSET(64'h100)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .front_rd_hbm_edge_addr  (front_addr),
    .front_rd_hbm_edge_valid (front_valid),
    .stage_full              (stage_full),
    .hbm_controller_full     (ctrl_full),
    .rd_hbm_edge_addr        (rd_addr),
    .rd_hbm_edge_valid       (rd_valid),
    .hbm_controller_edge     (ctrl_edge),
    .hbm_controller_valid    (ctrl_valid),
    .active_v_edge           (lane_data),
    .active_v_edge_valid     (lane_valid),
    .active_v_edge_ready     (lane_ready),
    .outstanding             (outstanding),
    .err_drop                (err_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [AW-1:0] a, input bit expect_issue);
    front_addr  = a;
    front_valid = 1'b1;
    if (expect_issue) exp_addr.push_back(a + AW'(64'h100));
    tick();
    front_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    ctrl_edge  = w;
    ctrl_valid = 1'b1;
    exp_word.push_back(w);
    tick();
    ctrl_valid = 1'b0;
  endtask

  // Monitor: compares every issue strobe and every lane transfer against the queues.
  always @(negedge clk) begin
    logic [DW-1:0] w;
    if (!rst_n) begin
      seen_mask = '0;
      exp_addr.delete();
      exp_word.delete();
    end else begin
      if (rd_valid) begin
        if (exp_addr.size() == 0) check("unexpected_issue", 64'(rd_addr), 64'h0 - 64'h1);
        else check("issue_addr", 64'(rd_addr), 64'(exp_addr.pop_front()));
      end
      for (int i = 0; i < int'(NL); i++) begin
        if (lane_valid[i] && lane_ready[i]) begin
          if (exp_word.size() == 0) begin
            check("unexpected_lane", 64'(i), 64'h0 - 64'h1);
          end else begin
            w = exp_word[0];
            check($sformatf("lane%0d_data", i), 64'(lane_data[i*LW +: LW]), 64'(w[i*LW +: LW]));
            seen_mask[i] = 1'b1;
          end
        end
      end
      if (&seen_mask) begin
        void'(exp_word.pop_front());
        seen_mask = '0;
      end
    end
  end

  initial begin
    logic [DW-1:0] wb;
    rst_n       = 1'b0;
    front_addr  = '0;
    front_valid = 1'b0;
    ctrl_full   = 1'b0;
    ctrl_edge   = '0;
    ctrl_valid  = 1'b0;
    lane_ready  = '0;
    tick();
    tick();
    check("rst_rd_valid",    64'(rd_valid),    64'h0);
    check("rst_stage_full",  64'(stage_full),  64'h0);
    check("rst_outstanding", 64'(outstanding), 64'h0);
    check("rst_lane_valid",  64'(lane_valid),  64'h0);
    check("rst_err_drop",    64'(err_drop),    64'h0);
    rst_n = 1'b1;
    tick();

    // T1: offset add and first-issue latency
    send_req(33'h20, 1'b1);
    check("t1_not_yet", 64'(rd_valid), 64'h0);
    tick();
    check("t1_valid", 64'(rd_valid), 64'h1);
    check("t1_addr",  64'(rd_addr),  64'h120);
    tick();
    check("t1_strobe_one_cycle", 64'(rd_valid), 64'h0);

    // T2: address wraps modulo 2^33
    send_req(33'h1_FFFF_FFFF, 1'b1);
    tick();
    check("t2_addr_wrap", 64'(rd_addr), 64'hFF);
    tick();
    check("t2_no_err", 64'(err_drop), 64'h0);
    check("t2_outstanding", 64'(outstanding), 64'd2);

    // T5: split lane handshake on a uniform word
    send_word({64{4'hA}});
    check("t5_all_valid", 64'(lane_valid), 64'hFF);
    lane_ready = 8'h0F;
    tick();
    check("t5_low_done", 64'(lane_valid), 64'hF0);
    check("t5_no_pop_yet", 64'(outstanding), 64'd2);
    lane_ready = 8'hF0;
    tick();
    check("t5_popped", 64'(outstanding), 64'd1);
    check("t5_empty", 64'(lane_valid), 64'h0);

    // Distinct lane contents with ready held high
    lane_ready = 8'hFF;
    for (int i = 0; i < int'(NL); i++) wb[i*LW +: LW] = 32'hC0DE_0000 + 32'(i);
    send_word(wb);
    tick();
    check("lane_map_outstanding", 64'(outstanding), 64'd0);
    lane_ready = 8'h00;

    // T3: stage_full threshold while the controller is full
    ctrl_full = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send_req(33'h1000 + 33'(i), 1'b1);
      check($sformatf("t3_stage_full_%0d", i + 1), 64'(stage_full), 64'(i + 1 >= 12));
    end
    ctrl_full = 1'b0;
    tick();
    for (int i = 0; i < 13; i++) begin
      check($sformatf("t3_burst_%0d", i), 64'(rd_valid), 64'h1);
      tick();
    end
    check("t3_burst_end", 64'(rd_valid), 64'h0);
    check("t3_outstanding", 64'(outstanding), 64'd13);

    // T4: credit exhaustion holds the 33rd request
    for (int i = 0; i < 20; i++) send_req(33'h2000 + 33'(i), 1'b1);
    repeat (4) tick();
    check("t4_outstanding_max", 64'(outstanding), 64'd32);
    check("t4_held", 64'(rd_valid), 64'h0);
    lane_ready = 8'hFF;
    send_word({8{32'h1357_9BDF}});
    tick();
    check("t4_after_pop", 64'(outstanding), 64'd31);
    check("t4_no_issue_yet", 64'(rd_valid), 64'h0);
    tick();
    check("t4_released", 64'(rd_valid), 64'h1);
    check("t4_outstanding_back", 64'(outstanding), 64'd32);
    lane_ready = 8'h00;

    // T6: asynchronous reset in the middle of a request burst
    front_valid = 1'b1;
    front_addr  = 33'h3000;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rd_valid",    64'(rd_valid),    64'h0);
    check("t6_outstanding", 64'(outstanding), 64'h0);
    check("t6_stage_full",  64'(stage_full),  64'h0);
    check("t6_err_drop",    64'(err_drop),    64'h0);
    front_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_post_outstanding", 64'(outstanding), 64'h0);
    for (int i = 0; i < 32; i++) send_req(33'h4000 + 33'(i), 1'b1);
    repeat (3) tick();
    check("t6_refill_outstanding", 64'(outstanding), 64'd32);

    // Request FIFO overflow sets the sticky drop flag
    for (int i = 0; i < 16; i++) send_req(33'h5000 + 33'(i), 1'b0);
    check("ovf_before", 64'(err_drop), 64'h0);
    send_req(33'h5FFF, 1'b0);
    check("ovf_after", 64'(err_drop), 64'h1);
    tick();
    check("ovf_sticky", 64'(err_drop), 64'h1);

    check("sb_addr_drained", 64'(exp_addr.size()), 64'h0);
    check("sb_word_drained", 64'(exp_word.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
